// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and constants for the shared-ALU controller
package alu_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // On a tie the port that was not served last wins.
   function automatic logic pick_winner(input logic req0, input logic req1,
                                        input logic last_grant);
      if (req0 && req1) return ~last_grant;
      else if (req1)    return PORT1;
      else              return PORT0;
   endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// rtl/alu_share_ctrl_alu.sv - combinational 32-bit ALU shared by both ports
module alu_share_ctrl_alu
   import alu_share_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  aluc,
   output logic [31:0] s,
   output logic        z
);

   // Shift ops take the amount from a and shift b.
   always_comb begin
      s = 32'd0;
      case (aluc)
         ALU_ADD: s = a + b;
         ALU_SUB: s = a - b;
         ALU_AND: s = a & b;
         ALU_OR:  s = a | b;
         ALU_XOR: s = a ^ b;
         ALU_LUI: s = {b[15:0], 16'd0};
         ALU_SLL: s = b << a[4:0];
         ALU_SRL: s = b >> a[4:0];
         ALU_SRA: s = $unsigned($signed(b) >>> a[4:0]);
         default: s = 32'd0;
      endcase
   end

   assign z = (s == 32'd0);

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin two-port arbiter and sequencer for one shared ALU
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             req0,
   input  logic [31:0]      a0,
   input  logic [31:0]      b0,
   input  logic [3:0]       aluc0,
   output logic             ack0,
   output logic [31:0]      r0,
   output logic             z0,
   input  logic             req1,
   input  logic [31:0]      a1,
   input  logic [31:0]      b1,
   input  logic [3:0]       aluc1,
   output logic             ack1,
   output logic [31:0]      r1,
   output logic             z1,
   output logic             busy,
   output logic [CNT_W-1:0] ops_cnt
);

   state_t             state_q;
   logic [31:0]        opa_q, opb_q;
   logic [3:0]         opc_q;
   logic               owner_q, last_grant_q;
   logic               ack0_q, ack1_q, busy_q;
   logic [31:0]        r0_q, r1_q;
   logic               z0_q, z1_q;
   logic [CNT_W-1:0]   ops_cnt_q;
   logic               winner_d;
   logic [31:0]        alu_s;
   logic               alu_z;

   assign winner_d = pick_winner(req0, req1, last_grant_q);

   alu_share_ctrl_alu u_alu (
      .a    (opa_q),
      .b    (opb_q),
      .aluc (opc_q),
      .s    (alu_s),
      .z    (alu_z)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         opa_q        <= 32'd0;
         opb_q        <= 32'd0;
         opc_q        <= 4'd0;
         owner_q      <= PORT0;
         last_grant_q <= PORT1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         r0_q         <= 32'd0;
         r1_q         <= 32'd0;
         z0_q         <= 1'b0;
         z1_q         <= 1'b0;
         ops_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  owner_q <= winner_d;
                  opa_q   <= (winner_d == PORT1) ? a1    : a0;
                  opb_q   <= (winner_d == PORT1) ? b1    : b0;
                  opc_q   <= (winner_d == PORT1) ? aluc1 : aluc0;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            // Result lands in the owner's registers on the same edge that raises its ack.
            EXEC: begin
               if (owner_q == PORT1) begin
                  r1_q   <= alu_s;
                  z1_q   <= alu_z;
                  ack1_q <= 1'b1;
               end else begin
                  r0_q   <= alu_s;
                  z0_q   <= alu_z;
                  ack0_q <= 1'b1;
               end
               state_q <= DONE;
            end
            DONE: begin
               ack0_q       <= 1'b0;
               ack1_q       <= 1'b0;
               busy_q       <= 1'b0;
               last_grant_q <= owner_q;
               ops_cnt_q    <= ops_cnt_q + CNT_W'(1);
               state_q      <= IDLE;
            end
            default: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign r0      = r0_q;
   assign r1      = r1_q;
   assign z0      = z0_q;
   assign z1      = z1_q;
   assign busy    = busy_q;
   assign ops_cnt = ops_cnt_q;

endmodule
